// File: rtl/seg7_pkg.sv
// Shared constants for the seven-segment scan controller: register map,
// hex glyph table (active-low a..g) and the blank pattern.
package seg7_pkg;

    localparam logic [1:0] ADDR_DATA  = 2'd0;
    localparam logic [1:0] ADDR_DP    = 2'd1;
    localparam logic [1:0] ADDR_CTRL  = 2'd2;
    localparam logic [1:0] ADDR_BLINK = 2'd3;

    localparam logic [7:0] SEG_BLANK = 8'hFF;

    // Segments a..g in bits 0..6, a cleared bit lights the segment.
    localparam logic [6:0] HEX_SEG [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    function automatic logic [31:0] byte_merge(
        input logic [31:0] old_val,
        input logic [31:0] new_val,
        input logic [3:0]  be
    );
        logic [31:0] mask;
        mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
        return (old_val & ~mask) | (new_val & mask);
    endfunction

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational hex nibble to active-low segment decoder; dp drives bit 7.
module seg7_hex_decode
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       dp,
    output logic [7:0] seg
);

    assign seg = {~dp, HEX_SEG[nibble]};

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Multiplexed seven-segment scanner with DATA/DP/CTRL/BLINK registers.
// Per-digit blinking is only built when SEG7_BLINK_EN is defined.
module seg7_scan_ctrl
    import seg7_pkg::*;
#(
    parameter int DIGITS    = 8,
    parameter int SCAN_DIV  = 100000,
    parameter int BLINK_DIV = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        PrAddr,
    input  logic [31:0]       PrWD,
    input  logic [3:0]        PrBE,
    input  logic              IOWrite,
    output logic [31:0]       PrRD,
    output logic [7:0]        seg7_seg,
    output logic [DIGITS-1:0] seg7_select
);

    localparam int DATA_W = 4 * DIGITS;
    localparam int PRE_W  = $clog2(SCAN_DIV);
    localparam int IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

    logic [DATA_W-1:0] data_reg;
    logic [DIGITS-1:0] dp_reg;
    logic              enable;
    logic [PRE_W-1:0]  pre_cnt;
    logic [IDX_W-1:0]  idx;
    logic [31:0]       wr_val;
    logic              pre_wrap;
    logic              digit_blank;
    logic [7:0]        digit_seg;

`ifdef SEG7_BLINK_EN
    localparam int BC_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [BC_W-1:0] BC_LAST = BC_W'(BLINK_DIV - 1);

    logic [DIGITS-1:0] blink_reg;
    logic [BC_W-1:0]   blink_cnt;
    logic              blink_off;

    assign digit_blank = blink_off & blink_reg[idx];
`else
    assign digit_blank = 1'b0;
`endif

    always_comb begin
        PrRD = '0;
        case (PrAddr)
            ADDR_DATA:  PrRD = 32'(data_reg);
            ADDR_DP:    PrRD = 32'(dp_reg);
            ADDR_CTRL:  PrRD = 32'(enable);
`ifdef SEG7_BLINK_EN
            ADDR_BLINK: PrRD = 32'(blink_reg);
`endif
            default:    PrRD = '0;
        endcase
    end

    // The read mux already selects the addressed register, so it doubles as the merge source.
    assign wr_val = byte_merge(PrRD, PrWD, PrBE);

    always_ff @(posedge clk) begin
        if (!rst) begin
            data_reg  <= '0;
            dp_reg    <= '0;
            enable    <= 1'b0;
`ifdef SEG7_BLINK_EN
            blink_reg <= '0;
`endif
        end else if (IOWrite) begin
            case (PrAddr)
                ADDR_DATA:  data_reg  <= DATA_W'(wr_val);
                ADDR_DP:    dp_reg    <= DIGITS'(wr_val);
                ADDR_CTRL:  enable    <= wr_val[0];
`ifdef SEG7_BLINK_EN
                ADDR_BLINK: blink_reg <= DIGITS'(wr_val);
`endif
                default: ;
            endcase
        end
    end

    assign pre_wrap = (pre_cnt == PRE_LAST);

    always_ff @(posedge clk) begin
        if (!rst || !enable) begin
            pre_cnt <= '0;
            idx     <= '0;
        end else if (pre_wrap) begin
            pre_cnt <= '0;
            idx     <= (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);
        end else begin
            pre_cnt <= pre_cnt + PRE_W'(1);
        end
    end

`ifdef SEG7_BLINK_EN
    // Blink phase restarts visible whenever the display is disabled.
    always_ff @(posedge clk) begin
        if (!rst || !enable) begin
            blink_cnt <= '0;
            blink_off <= 1'b0;
        end else if (pre_wrap && idx == IDX_LAST) begin
            if (blink_cnt == BC_LAST) begin
                blink_cnt <= '0;
                blink_off <= ~blink_off;
            end else begin
                blink_cnt <= blink_cnt + BC_W'(1);
            end
        end
    end
`endif

    seg7_hex_decode u_hex_decode (
        .nibble (data_reg[{idx, 2'b00} +: 4]),
        .dp     (dp_reg[idx]),
        .seg    (digit_seg)
    );

    always_ff @(posedge clk) begin
        if (!rst || !enable) begin
            seg7_seg    <= SEG_BLANK;
            seg7_select <= '1;
        end else begin
            seg7_seg    <= digit_blank ? SEG_BLANK : digit_seg;
            seg7_select <= ~(DIGITS'(1) << idx);
        end
    end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Bench for seg7_scan_ctrl: random register traffic checked every cycle against
// a cycle-count model of the scan, plus literal glyph and timing expectations.
module tb_seg7_scan_ctrl;

    localparam int DIGITS    = 4;
    localparam int SCAN_DIV  = 4;
    localparam int BLINK_DIV = 2;

    localparam logic [1:0] A_DATA  = 2'd0;
    localparam logic [1:0] A_DP    = 2'd1;
    localparam logic [1:0] A_CTRL  = 2'd2;
    localparam logic [1:0] A_BLINK = 2'd3;

    // Standard active-low glyphs with the dp segment (bit 7) off.
    localparam logic [7:0] GLYPH [16] = '{
        8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
        8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
    };

    logic              clk = 1'b0;
    logic              rst;
    logic [1:0]        PrAddr;
    logic [31:0]       PrWD;
    logic [3:0]        PrBE;
    logic              IOWrite;
    logic [31:0]       PrRD;
    logic [7:0]        seg7_seg;
    logic [DIGITS-1:0] seg7_select;

    int n_vec  = 0;
    int n_miss = 0;

    logic [31:0]     m_data, m_dp, m_ctrl, m_blink;
    longint unsigned en_cycles;
    logic [7:0]      exp_seg;
    logic [3:0]      exp_sel;
    bit              model_valid = 1'b0;

    seg7_scan_ctrl #(
        .DIGITS    (DIGITS),
        .SCAN_DIV  (SCAN_DIV),
        .BLINK_DIV (BLINK_DIV)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .PrAddr      (PrAddr),
        .PrWD        (PrWD),
        .PrBE        (PrBE),
        .IOWrite     (IOWrite),
        .PrRD        (PrRD),
        .seg7_seg    (seg7_seg),
        .seg7_select (seg7_select)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mergeBytes(input logic [31:0] old_val,
                                               input logic [31:0] wd,
                                               input logic [3:0]  be);
        logic [31:0] r;
        r = old_val;
        for (int b = 0; b < 4; b++)
            if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
        return r;
    endfunction

    function automatic logic [31:0] modelRead(input logic [1:0] addr);
        case (addr)
            A_DATA:  return m_data;
            A_DP:    return m_dp;
            A_CTRL:  return m_ctrl;
`ifdef SEG7_BLINK_EN
            A_BLINK: return m_blink;
`endif
            default: return 32'h0;
        endcase
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_miss++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, req, $time);
        end
    endtask

    task automatic applyStimulus(input logic [1:0] addr, input logic [31:0] wd, input logic [3:0] be);
        @(posedge clk); #1;
        PrAddr  = addr;
        PrWD    = wd;
        PrBE    = be;
        IOWrite = 1'b1;
        @(posedge clk); #1;
        IOWrite = 1'b0;
    endtask

    task automatic waitSelect(input logic [3:0] pat, input string name);
        bit found;
        found = 1'b0;
        for (int i = 0; i < 64 && !found; i++) begin
            @(negedge clk);
            if (seg7_select === pat) found = 1'b1;
        end
        if (!found) begin
            n_vec++;
            n_miss++;
            $display("[TB] FAIL %s: select is %b, expected %b within 64 cycles", name, seg7_select, pat);
        end
    endtask

    task automatic checkDigit(input logic [3:0] pat, input logic [7:0] req, input string name);
        waitSelect(pat, name);
        checkOutput(name, 32'(seg7_seg), 32'(req));
    endtask

    // Reference: the displayed digit follows purely from how many cycles ENABLE has been set.
    always @(posedge clk) begin : ref_model
        int d;
        logic [7:0] s;
        if (!rst) begin
            m_data    = '0;
            m_dp      = '0;
            m_ctrl    = '0;
            m_blink   = '0;
            en_cycles = 0;
            exp_seg   = 8'hFF;
            exp_sel   = 4'hF;
        end else begin
            if (m_ctrl[0]) begin
                d = int'((en_cycles / SCAN_DIV) % DIGITS);
                s = GLYPH[4'(m_data >> (4 * d))];
                if (m_dp[d]) s[7] = 1'b0;
`ifdef SEG7_BLINK_EN
                if ((((en_cycles / (SCAN_DIV * DIGITS)) / BLINK_DIV) % 2) == 1 && m_blink[d])
                    s = 8'hFF;
`endif
                exp_seg = s;
                exp_sel = ~(4'b0001 << d);
                en_cycles++;
            end else begin
                exp_seg   = 8'hFF;
                exp_sel   = 4'hF;
                en_cycles = 0;
            end
            if (IOWrite) begin
                case (PrAddr)
                    A_DATA: m_data = mergeBytes(m_data, PrWD, PrBE) & 32'h0000FFFF;
                    A_DP:   m_dp   = mergeBytes(m_dp,   PrWD, PrBE) & 32'h0000000F;
                    A_CTRL: m_ctrl = mergeBytes(m_ctrl, PrWD, PrBE) & 32'h00000001;
                    default: begin
`ifdef SEG7_BLINK_EN
                        m_blink = mergeBytes(m_blink, PrWD, PrBE) & 32'h0000000F;
`endif
                    end
                endcase
            end
        end
        model_valid = 1'b1;
    end

    always @(negedge clk) begin
        if (model_valid) begin
            checkOutput("seg", 32'(seg7_seg), 32'(exp_seg));
            checkOutput("select", 32'(seg7_select), 32'(exp_sel));
            checkOutput("prrd", PrRD, modelRead(PrAddr));
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: still running at %0t, limit 500000", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : driver
        int cnt;
        int blank_cnt;
        int vis_cnt;
        logic [3:0] first_sel;

        rst = 1'b0; IOWrite = 1'b0; PrAddr = A_DATA; PrWD = '0; PrBE = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_seg", 32'(seg7_seg), 32'hFF);
        checkOutput("reset_select", 32'(seg7_select), 32'hF);
        @(posedge clk); #1 rst = 1'b1;

        applyStimulus(A_CTRL, 32'h1, 4'hF);
        applyStimulus(A_DATA, 32'h0000_1234, 4'hF);
        repeat (2) @(posedge clk);
        checkDigit(4'b1101, 8'hB0, "scan_digit1");
        checkDigit(4'b1011, 8'hA4, "scan_digit2");
        checkDigit(4'b0111, 8'hF9, "scan_digit3");
        checkDigit(4'b1110, 8'h99, "scan_digit0");

        applyStimulus(A_DATA, 32'hFFFF_0000, 4'b0001);
        @(negedge clk);
        checkOutput("data_partial_read", PrRD, 32'h0000_1200);
        repeat (2) @(posedge clk);
        checkDigit(4'b1110, 8'hC0, "partial_digit0");
        checkDigit(4'b1101, 8'hC0, "partial_digit1");
        checkDigit(4'b1011, 8'hA4, "partial_digit2");

        applyStimulus(A_DP, 32'h4, 4'hF);
        applyStimulus(A_DATA, 32'h0000_ABCD, 4'hF);
        repeat (2) @(posedge clk);
        checkDigit(4'b1011, 8'h03, "dp_digit2");
        checkDigit(4'b0111, 8'h88, "nodp_digit3");
        checkDigit(4'b1110, 8'hA1, "nodp_digit0");
        checkDigit(4'b1101, 8'hC6, "nodp_digit1");

        waitSelect(4'b1101, "mid_round");
        applyStimulus(A_CTRL, 32'h0, 4'hF);
        @(negedge clk);
        @(negedge clk);
        checkOutput("disable_seg", 32'(seg7_seg), 32'hFF);
        checkOutput("disable_select", 32'(seg7_select), 32'hF);
        applyStimulus(A_CTRL, 32'h1, 4'hF);
        cnt = 0;
        first_sel = 4'hF;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (first_sel === 4'hF && seg7_select !== 4'hF) first_sel = seg7_select;
            if (seg7_select === 4'b1110) cnt++;
            else if (cnt > 0) break;
        end
        checkOutput("reenable_first_digit", 32'(first_sel), 32'hE);
        checkOutput("reenable_dwell", cnt, 32'd4);

        for (int i = 0; i < 900; i++) begin
            @(posedge clk); #1;
            rst     = ($urandom_range(0, 199) != 0);
            PrAddr  = 2'($urandom_range(0, 3));
            PrBE    = 4'($urandom);
            PrWD    = $urandom;
            IOWrite = ($urandom_range(0, 3) == 0);
            if (PrAddr == A_CTRL) PrWD[0] = ($urandom_range(0, 9) != 0);
        end
        @(posedge clk); #1;
        rst = 1'b1; IOWrite = 1'b0;

        applyStimulus(A_CTRL, 32'h1, 4'hF);
        applyStimulus(A_DATA, 32'h0000_5678, 4'hF);
        repeat (2) @(posedge clk);
        waitSelect(4'b1011, "pre_reset_digit2");
        rst = 1'b0;
        @(negedge clk);
        checkOutput("midscan_reset_seg", 32'(seg7_seg), 32'hFF);
        checkOutput("midscan_reset_select", 32'(seg7_select), 32'hF);
        for (int a = 0; a < 4; a++) begin
            PrAddr = 2'(a);
            #1;
            checkOutput($sformatf("midscan_reset_reg%0d", a), PrRD, 32'h0);
        end
        @(posedge clk); #1 rst = 1'b1;

`ifdef SEG7_BLINK_EN
        applyStimulus(A_DATA, 32'h0000_1234, 4'hF);
        applyStimulus(A_BLINK, 32'h1, 4'hF);
        applyStimulus(A_CTRL, 32'h1, 4'hF);
        blank_cnt = 0;
        vis_cnt   = 0;
        repeat (128) begin
            @(negedge clk);
            if (seg7_select === 4'b1110) begin
                if (seg7_seg === 8'hFF) blank_cnt++;
                else vis_cnt++;
            end
        end
        checkOutput("blink_blank_cycles", blank_cnt, 32'd16);
        checkOutput("blink_visible_cycles", vis_cnt, 32'd16);
`else
        blank_cnt = 0;
        vis_cnt   = 0;
        applyStimulus(A_BLINK, 32'hF, 4'hF);
        @(negedge clk);
        checkOutput("blink_addr_reads_zero", PrRD, 32'h0);
`endif

        repeat (2) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
